// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocation for the dispatcher, result capture from
// the CDB, in-order retirement into the register file and branch-mispredict
// flush. ROB ID = slot index + 1, so ID 0 always means "no producer".
module rob_commit_unit #(
   parameter int ROB_SIZE = 16,
   parameter int ROB_ID_W = 5,
   parameter int DATA_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                alloc_valid,
   input  logic [1:0]          alloc_type,
   input  logic [4:0]          alloc_rd,
   input  logic                alloc_pred_taken,
   input  logic [DATA_W-1:0]   alloc_pc,
   output logic [ROB_ID_W-1:0] alloc_id,
   output logic                rob_full,
   input  logic                cdb_valid,
   input  logic [ROB_ID_W-1:0] cdb_id,
   input  logic [DATA_W-1:0]   cdb_value,
   input  logic                cdb_taken,
   input  logic [DATA_W-1:0]   cdb_target,
   input  logic [ROB_ID_W-1:0] query_id1,
   input  logic [ROB_ID_W-1:0] query_id2,
   output logic                query_ready1,
   output logic                query_ready2,
   output logic [DATA_W-1:0]   query_value1,
   output logic [DATA_W-1:0]   query_value2,
   output logic                enable_to_rf,
   output logic [4:0]          rd_to_rf,
   output logic [ROB_ID_W-1:0] Q_to_rf,
   output logic [DATA_W-1:0]   V_to_rf,
   output logic                mispredict,
   output logic [DATA_W-1:0]   redirect_pc
);

   localparam int IDX_W = $clog2(ROB_SIZE);

   localparam logic [1:0] TYPE_REG    = 2'd0;
   localparam logic [1:0] TYPE_BRANCH = 2'd1;

   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [IDX_W:0]   count;

   logic              slot_valid  [ROB_SIZE];
   logic              slot_ready  [ROB_SIZE];
   logic [1:0]        slot_type   [ROB_SIZE];
   logic [4:0]        slot_rd     [ROB_SIZE];
   logic              slot_pred   [ROB_SIZE];
   logic [DATA_W-1:0] slot_pc     [ROB_SIZE];
   logic [DATA_W-1:0] slot_value  [ROB_SIZE];
   logic              slot_taken  [ROB_SIZE];
   logic [DATA_W-1:0] slot_target [ROB_SIZE];

   logic             cdb_ok;
   logic [IDX_W-1:0] cdb_idx;
   logic             alloc_fire;
   logic             commit_fire;
   logic             commit_write;
   logic             commit_flush;
   logic [IDX_W-1:0] q_idx1;
   logic [IDX_W-1:0] q_idx2;

   // IDs 1..ROB_SIZE name a slot; 0 and anything above the ROB size do not.
   function automatic logic id_in_range(input logic [ROB_ID_W-1:0] id);
      return (id != '0) && (id <= ROB_ID_W'(ROB_SIZE));
   endfunction

   // Allocation/commit decisions; rob_full alone gates allocation so a
   // same-cycle commit never frees a slot early.
   always_comb begin
      alloc_id     = ROB_ID_W'(tail) + ROB_ID_W'(1);
      rob_full     = (count == (IDX_W+1)'(ROB_SIZE));
      cdb_ok       = cdb_valid && id_in_range(cdb_id);
      cdb_idx      = IDX_W'(cdb_id - ROB_ID_W'(1));
      alloc_fire   = rdy && alloc_valid && !rob_full && !mispredict;
      commit_fire  = rdy && (count != '0) && slot_ready[head];
      commit_write = commit_fire && (slot_type[head] == TYPE_REG) && (slot_rd[head] != '0);
      commit_flush = commit_fire && (slot_type[head] == TYPE_BRANCH)
                     && (slot_taken[head] != slot_pred[head]);
   end

   // Operand lookup for the dispatcher, with same-cycle CDB bypass.
   always_comb begin
      q_idx1       = IDX_W'(query_id1 - ROB_ID_W'(1));
      q_idx2       = IDX_W'(query_id2 - ROB_ID_W'(1));
      query_ready1 = 1'b0;
      query_value1 = '0;
      query_ready2 = 1'b0;
      query_value2 = '0;
      if (id_in_range(query_id1)) begin
         if (cdb_ok && (cdb_id == query_id1)) begin
            query_ready1 = 1'b1;
            query_value1 = cdb_value;
         end else if (slot_valid[q_idx1] && slot_ready[q_idx1]) begin
            query_ready1 = 1'b1;
            query_value1 = slot_value[q_idx1];
         end
      end
      if (id_in_range(query_id2)) begin
         if (cdb_ok && (cdb_id == query_id2)) begin
            query_ready2 = 1'b1;
            query_value2 = cdb_value;
         end else if (slot_valid[q_idx2] && slot_ready[q_idx2]) begin
            query_ready2 = 1'b1;
            query_value2 = slot_value[q_idx2];
         end
      end
   end

   // Pointers, occupancy and per-slot state; a mispredict flush overrides
   // every other update in its cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            slot_valid[i] <= 1'b0;
            slot_ready[i] <= 1'b0;
         end
      end else if (rdy) begin
         if (commit_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
               slot_valid[i] <= 1'b0;
               slot_ready[i] <= 1'b0;
            end
         end else begin
            if (alloc_fire) begin
               slot_valid[tail] <= 1'b1;
               slot_ready[tail] <= 1'b0;
               slot_type[tail]  <= alloc_type;
               slot_rd[tail]    <= alloc_rd;
               slot_pred[tail]  <= alloc_pred_taken;
               slot_pc[tail]    <= alloc_pc;
               tail             <= tail + IDX_W'(1);
            end
            // Only live entries capture results; a stale ID is dropped.
            if (cdb_ok && slot_valid[cdb_idx]) begin
               slot_ready[cdb_idx]  <= 1'b1;
               slot_value[cdb_idx]  <= cdb_value;
               slot_taken[cdb_idx]  <= cdb_taken;
               slot_target[cdb_idx] <= cdb_target;
            end
            if (commit_fire) begin
               slot_valid[head] <= 1'b0;
               slot_ready[head] <= 1'b0;
               head             <= head + IDX_W'(1);
            end
            count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
         end
      end
   end

   // Registered commit interface: pulses last one cycle, data holds between commits.
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_to_rf <= 1'b0;
         rd_to_rf     <= '0;
         Q_to_rf      <= '0;
         V_to_rf      <= '0;
         mispredict   <= 1'b0;
         redirect_pc  <= '0;
      end else if (!rdy) begin
         enable_to_rf <= 1'b0;
         mispredict   <= 1'b0;
      end else begin
         enable_to_rf <= commit_write;
         mispredict   <= commit_flush;
         if (commit_write) begin
            rd_to_rf <= slot_rd[head];
            Q_to_rf  <= ROB_ID_W'(head) + ROB_ID_W'(1);
            V_to_rf  <= slot_value[head];
         end
         if (commit_flush) begin
            redirect_pc <= slot_taken[head] ? slot_target[head]
                                            : slot_pc[head] + DATA_W'(4);
         end
      end
   end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: expected commits are queued as stimulus is driven
// and matched against every enable_to_rf/mispredict pulse the DUT produces.
module tb_rob_commit_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        alloc_valid = 1'b0;
   logic [1:0]  alloc_type = '0;
   logic [4:0]  alloc_rd = '0;
   logic        alloc_pred_taken = 1'b0;
   logic [31:0] alloc_pc = '0;
   logic [4:0]  alloc_id;
   logic        rob_full;
   logic        cdb_valid = 1'b0;
   logic [4:0]  cdb_id = '0;
   logic [31:0] cdb_value = '0;
   logic        cdb_taken = 1'b0;
   logic [31:0] cdb_target = '0;
   logic [4:0]  query_id1 = '0;
   logic [4:0]  query_id2 = '0;
   logic        query_ready1, query_ready2;
   logic [31:0] query_value1, query_value2;
   logic        enable_to_rf;
   logic [4:0]  rd_to_rf;
   logic [4:0]  Q_to_rf;
   logic [31:0] V_to_rf;
   logic        mispredict;
   logic [31:0] redirect_pc;

   rob_commit_unit dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
      .alloc_pred_taken(alloc_pred_taken), .alloc_pc(alloc_pc),
      .alloc_id(alloc_id), .rob_full(rob_full),
      .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
      .cdb_taken(cdb_taken), .cdb_target(cdb_target),
      .query_id1(query_id1), .query_id2(query_id2),
      .query_ready1(query_ready1), .query_ready2(query_ready2),
      .query_value1(query_value1), .query_value2(query_value2),
      .enable_to_rf(enable_to_rf), .rd_to_rf(rd_to_rf), .Q_to_rf(Q_to_rf),
      .V_to_rf(V_to_rf), .mispredict(mispredict), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [4:0]  rd;
      logic [4:0]  q;
      logic [31:0] v;
      logic        mp;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   exp_t exp_e;
   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;
   int   commit_cyc[$];
   logic bad;

   // Cycle counter used to time-stamp commit pulses.
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every commit pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && (enable_to_rf === 1'b1 || mispredict === 1'b1)) begin
         commit_cyc.push_back(cyc);
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_commit: got en=%0b rd=%0d q=%0d v=%h mp=%0b pc=%h, expected no pulse",
                     enable_to_rf, rd_to_rf, Q_to_rf, V_to_rf, mispredict, redirect_pc);
         end else begin
            exp_e = sb.pop_front();
            bad = (enable_to_rf !== exp_e.en) || (mispredict !== exp_e.mp);
            if (exp_e.en && ((rd_to_rf !== exp_e.rd) || (Q_to_rf !== exp_e.q) || (V_to_rf !== exp_e.v)))
               bad = 1'b1;
            if (exp_e.mp && (redirect_pc !== exp_e.pc))
               bad = 1'b1;
            if (bad) begin
               mismatched++;
               $display("FAIL commit_match: got en=%0b rd=%0d q=%0d v=%h mp=%0b pc=%h, expected en=%0b rd=%0d q=%0d v=%h mp=%0b pc=%h",
                        enable_to_rf, rd_to_rf, Q_to_rf, V_to_rf, mispredict, redirect_pc,
                        exp_e.en, exp_e.rd, exp_e.q, exp_e.v, exp_e.mp, exp_e.pc);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic apply_reset();
      rst = 1'b1;
      rdy = 1'b1;
      alloc_valid = 1'b0;
      cdb_valid = 1'b0;
      query_id1 = '0;
      query_id2 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic do_alloc(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                           input logic [31:0] pc, output logic [4:0] id);
      alloc_valid = 1'b1;
      alloc_type = t;
      alloc_rd = rd;
      alloc_pred_taken = pred;
      alloc_pc = pc;
      #1 id = alloc_id;
      @(posedge clk);
      #1 alloc_valid = 1'b0;
   endtask

   task automatic do_cdb(input logic [4:0] id, input logic [31:0] val, input logic taken,
                         input logic [31:0] tgt);
      cdb_valid = 1'b1;
      cdb_id = id;
      cdb_value = val;
      cdb_taken = taken;
      cdb_target = tgt;
      @(posedge clk);
      #1 cdb_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL %s_drain: %0d commits still pending, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (enable_to_rf !== 1'b0 || mispredict !== 1'b0 || rd_to_rf !== 5'd0 || Q_to_rf !== 5'd0
          || V_to_rf !== 32'd0 || redirect_pc !== 32'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: got en=%0b mp=%0b rd=%0d q=%0d v=%h pc=%h, expected all 0",
                  enable_to_rf, mispredict, rd_to_rf, Q_to_rf, V_to_rf, redirect_pc);
      end
      compared++;
      if (alloc_id !== 5'd1 || rob_full !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_ptrs: got alloc_id=%0d full=%0b, expected 1 0", alloc_id, rob_full);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [4:0] id;
      apply_reset();
      do_alloc(2'd0, 5'd5, 1'b0, 32'h40, id);
      compared++;
      if (id !== 5'd1) begin
         mismatched++;
         $display("FAIL basic_alloc_id: got %0d, expected 1", id);
      end
      sb.push_back('{1'b1, 5'd5, 5'd1, 32'h1234, 1'b0, 32'h0});
      do_cdb(5'd1, 32'h1234, 1'b0, 32'h0);
      drain("basic");
   endtask

   task automatic test_full_wrap();
      logic [4:0] id;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         do_alloc(2'd0, 5'(i + 1), 1'b0, 32'(i * 4), id);
         compared++;
         if (id !== 5'(i + 1)) begin
            mismatched++;
            $display("FAIL full_alloc_id: got %0d, expected %0d", id, i + 1);
         end
      end
      compared++;
      if (rob_full !== 1'b1) begin
         mismatched++;
         $display("FAIL full_flag: got %0b, expected 1", rob_full);
      end
      do_alloc(2'd0, 5'd20, 1'b0, 32'h80, id);
      compared++;
      if (rob_full !== 1'b1 || alloc_id !== 5'd1) begin
         mismatched++;
         $display("FAIL full_17th_ignored: got full=%0b alloc_id=%0d, expected 1 1", rob_full, alloc_id);
      end
      sb.push_back('{1'b1, 5'd1, 5'd1, 32'hA1, 1'b0, 32'h0});
      do_cdb(5'd1, 32'hA1, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      compared++;
      if (rob_full !== 1'b0 || alloc_id !== 5'd1) begin
         mismatched++;
         $display("FAIL full_after_commit: got full=%0b alloc_id=%0d, expected 0 1", rob_full, alloc_id);
      end
      drain("full_wrap");
   endtask

   task automatic test_mispredict_taken();
      logic [4:0] id;
      logic found = 1'b0;
      apply_reset();
      do_alloc(2'd1, 5'd0, 1'b0, 32'h100, id);
      do_alloc(2'd0, 5'd7, 1'b0, 32'h104, id);
      do_cdb(5'd2, 32'h77, 1'b0, 32'h0);
      sb.push_back('{1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 32'h200});
      do_cdb(5'd1, 32'h0, 1'b1, 32'h200);
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         if (mispredict === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("FAIL taken_flush_seen: got no mispredict within 10 cycles, expected pulse");
      end
      alloc_valid = 1'b1;
      alloc_type = 2'd0;
      alloc_rd = 5'd3;
      alloc_pc = 32'h300;
      #1;
      compared++;
      if (alloc_id !== 5'd1 || rob_full !== 1'b0) begin
         mismatched++;
         $display("FAIL taken_flush_ptrs: got alloc_id=%0d full=%0b, expected 1 0", alloc_id, rob_full);
      end
      @(posedge clk);
      #1 alloc_valid = 1'b0;
      compared++;
      if (alloc_id !== 5'd1 || mispredict !== 1'b0) begin
         mismatched++;
         $display("FAIL taken_flush_alloc_rejected: got alloc_id=%0d mp=%0b, expected 1 0", alloc_id, mispredict);
      end
      do_cdb(5'd2, 32'h99, 1'b0, 32'h0);
      drain("taken_flush");
   endtask

   task automatic test_mispredict_not_taken();
      logic [4:0] id;
      apply_reset();
      do_alloc(2'd1, 5'd0, 1'b1, 32'h100, id);
      sb.push_back('{1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 32'h104});
      do_cdb(5'd1, 32'h0, 1'b0, 32'h999);
      drain("nt_flush");
      do_alloc(2'd1, 5'd0, 1'b0, 32'h300, id);
      do_cdb(5'd1, 32'h0, 1'b0, 32'h0);
      do_alloc(2'd0, 5'd3, 1'b0, 32'h304, id);
      compared++;
      if (id !== 5'd2) begin
         mismatched++;
         $display("FAIL nt_after_silent_id: got %0d, expected 2", id);
      end
      sb.push_back('{1'b1, 5'd3, 5'd2, 32'h33, 1'b0, 32'h0});
      do_cdb(5'd2, 32'h33, 1'b0, 32'h0);
      drain("nt_silent");
   endtask

   task automatic test_out_of_order();
      logic [4:0] id;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         do_alloc(2'd0, 5'(10 + i), 1'b0, 32'(i * 4), id);
         sb.push_back('{1'b1, 5'(10 + i), 5'(i + 1), 32'(32'h111 * (i + 1)), 1'b0, 32'h0});
      end
      commit_cyc.delete();
      do_cdb(5'd3, 32'h333, 1'b0, 32'h0);
      do_cdb(5'd2, 32'h222, 1'b0, 32'h0);
      do_cdb(5'd1, 32'h111, 1'b0, 32'h0);
      do_alloc(2'd2, 5'd0, 1'b0, 32'h40, id);
      compared++;
      if (id !== 5'd4) begin
         mismatched++;
         $display("FAIL ooo_alloc_during_commit: got id=%0d, expected 4", id);
      end
      drain("ooo");
      compared++;
      if (commit_cyc.size() != 3) begin
         mismatched++;
         $display("FAIL ooo_commit_count: got %0d pulses, expected 3", commit_cyc.size());
      end else if (commit_cyc[1] - commit_cyc[0] != 1 || commit_cyc[2] - commit_cyc[1] != 1) begin
         mismatched++;
         $display("FAIL ooo_consecutive: got cycles %0d %0d %0d, expected consecutive",
                  commit_cyc[0], commit_cyc[1], commit_cyc[2]);
      end
      compared++;
      if (alloc_id !== 5'd5 || rob_full !== 1'b0) begin
         mismatched++;
         $display("FAIL ooo_final_ptrs: got alloc_id=%0d full=%0b, expected 5 0", alloc_id, rob_full);
      end
   endtask

   task automatic test_query_bypass();
      logic [4:0] id;
      apply_reset();
      do_alloc(2'd0, 5'd0, 1'b0, 32'h0, id);
      do_alloc(2'd0, 5'd9, 1'b0, 32'h4, id);
      query_id1 = 5'd2;
      query_id2 = 5'd0;
      cdb_valid = 1'b1;
      cdb_id = 5'd2;
      cdb_value = 32'hAB;
      cdb_taken = 1'b0;
      #1;
      compared++;
      if (query_ready1 !== 1'b1 || query_value1 !== 32'hAB) begin
         mismatched++;
         $display("FAIL query_bypass: got rdy=%0b val=%h, expected 1 000000ab", query_ready1, query_value1);
      end
      compared++;
      if (query_ready2 !== 1'b0 || query_value2 !== 32'h0) begin
         mismatched++;
         $display("FAIL query_id0: got rdy=%0b val=%h, expected 0 0", query_ready2, query_value2);
      end
      @(posedge clk);
      #1 cdb_valid = 1'b0;
      query_id2 = 5'd1;
      #1;
      compared++;
      if (query_ready1 !== 1'b1 || query_value1 !== 32'hAB || query_ready2 !== 1'b0) begin
         mismatched++;
         $display("FAIL query_stored: got rdy1=%0b val1=%h rdy2=%0b, expected 1 000000ab 0",
                  query_ready1, query_value1, query_ready2);
      end
      @(posedge clk);
      #1;
      sb.push_back('{1'b1, 5'd9, 5'd2, 32'hAB, 1'b0, 32'h0});
      do_cdb(5'd1, 32'h55, 1'b0, 32'h0);
      drain("query_rd0");
      query_id1 = '0;
      query_id2 = '0;
   endtask

   task automatic test_rdy_freeze();
      logic [4:0] id;
      apply_reset();
      do_alloc(2'd0, 5'd4, 1'b0, 32'h0, id);
      rdy = 1'b0;
      do_cdb(5'd1, 32'h77, 1'b0, 32'h0);
      do_alloc(2'd0, 5'd6, 1'b0, 32'h4, id);
      compared++;
      if (alloc_id !== 5'd2) begin
         mismatched++;
         $display("FAIL rdy_alloc_frozen: got alloc_id=%0d, expected 2", alloc_id);
      end
      rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sb.push_back('{1'b1, 5'd4, 5'd1, 32'h78, 1'b0, 32'h0});
      do_cdb(5'd1, 32'h78, 1'b0, 32'h0);
      drain("rdy");
   endtask

   // Test sequence.
   initial begin
      test_reset();
      test_basic();
      test_full_wrap();
      test_mispredict_taken();
      test_mispredict_not_taken();
      test_out_of_order();
      test_query_bypass();
      test_rdy_freeze();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer for the Tomasulo core.
- Allocates entries in program order for the dispatcher and captures results from the common data bus (CDB).
- Retires entries in order into the register file over the rd/Q/V commit interface and raises the mispredict flush.
- Sits between the dispatcher/CDB and the register file; ROB ID 0 is reserved as "non-dependent".

Parameters:
- ROB_SIZE, 16, number of entries (power of two).
- ROB_ID_W, 5, ID width; ID = slot index + 1, so 0 is never a valid ID.
- DATA_W, 32, data and PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- alloc_valid  in  1  dispatcher requests an entry
- alloc_type  in  2  0 = reg-write, 1 = branch, 2 = no-dest (store/other)
- alloc_rd  in  5  destination register (used for type 0)
- alloc_pred_taken  in  1  predicted direction (type 1)
- alloc_pc  in  DATA_W  instruction PC
- alloc_id  out  ROB_ID_W  ID granted this cycle (combinational, tail+1)
- rob_full  out  1  count == ROB_SIZE
- cdb_valid  in  1  result broadcast
- cdb_id  in  ROB_ID_W  producing entry
- cdb_value  in  DATA_W  result value
- cdb_taken  in  1  resolved branch direction
- cdb_target  in  DATA_W  resolved taken target
- query_id1, query_id2  in  ROB_ID_W  dispatcher operand lookup
- query_ready1, query_ready2  out  1  entry has a result
- query_value1, query_value2  out  DATA_W  entry result
- enable_to_rf  out  1  commit write pulse
- rd_to_rf  out  5  committed rd
- Q_to_rf  out  ROB_ID_W  committed entry ID
- V_to_rf  out  DATA_W  committed value
- mispredict  out  1  flush pulse
- redirect_pc  out  DATA_W  correct fetch PC

Behaviour:
- Reset: head=tail=count=0; all entries invalid/not-ready; enable_to_rf=0, rd_to_rf=0, Q_to_rf=0, V_to_rf=0, mispredict=0, redirect_pc=0.
- rdy low: no state changes; enable_to_rf and mispredict are driven 0 at the edge.
- Allocation:
  - Accepted when alloc_valid && !rob_full && !mispredict.
  - The slot at tail is written with type, rd, pred, pc and ready=0.
  - tail wraps modulo ROB_SIZE.
  - rob_full blocks allocation even if a commit happens the same cycle.
- Write-back: on cdb_valid, the slot (cdb_id-1) stores value, taken and target, and ready=1. A cdb_id of 0 is ignored.
- Query:
  - Combinational. ID 0 returns ready=0, value=0.
  - On a same-cycle CDB hit (cdb_valid && cdb_id==query_id), returns ready=1 with cdb_value (bypass).
- Commit (at most one per cycle):
  - If count>0 and the head slot is ready at edge N, head advances and count decrements at N.
  - Outputs are registered and valid cycle N+1 for exactly one cycle.
  - Type 0 with rd!=0: enable_to_rf=1, rd_to_rf=rd, Q_to_rf=head ID, V_to_rf=value.
  - Type 0 with rd==0, and types 1/2: enable_to_rf=0.
  - Type 1 with taken != pred: mispredict=1 and redirect_pc = taken ? target : pc+4 at N+1.
  - On that mispredict, at edge N: head=tail=count=0 and all slots invalid; allocations and CDB writes in that cycle are discarded.
  - A branch with taken == pred retires silently.
- While mispredict=1 (cycle N+1): allocation is refused, alloc_id is still driven, and commit cannot occur because the ROB is empty.
- Simultaneous allocate and commit: count is unchanged; tail and head both advance.
- Wrap: IDs recycle. Slot 15 holds ID 16; the next allocation after it reuses slot 0, ID 1.
- Counters use log2(ROB_SIZE) bits plus one bit for count.

Test Plan:
- Reset, then allocate a type-0 entry with rd=5 -> alloc_id=1. CDB id=1, value=0x1234 -> next cycle enable_to_rf=1, rd_to_rf=5, Q_to_rf=1, V_to_rf=0x1234.
- Allocate 16 entries -> rob_full=1 and the 17th request is ignored. Complete entry 1 -> after commit rob_full=0; the next alloc_id=1 (wrap).
- Branch pc=0x100, pred=0. CDB taken=1, target=0x200 -> mispredict=1, redirect_pc=0x200, count=0. An alloc request in the flush cycle is rejected.
- Branch pc=0x100, pred=1. CDB taken=0 -> mispredict=1, redirect_pc=0x104. With pred=0 and taken=0 -> no mispredict, no enable_to_rf.
- Out-of-order completion: entries 1,2,3 with CDB order 3,2,1 -> commits occur in order 1,2,3 on consecutive cycles.
- query_id1=2 with cdb_id=2, value=0xAB in the same cycle -> query_ready1=1, query_value1=0xAB. Type-0 with rd=0 commits with enable_to_rf=0.
